// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner:
// active-low gfedcba hex glyphs, the all-off pattern and the scan FSM states.
package hex_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/hex_glyph_decode.sv
// Nibble to active-low gfedcba segment pattern; every code maps to a glyph.
module hex_glyph_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = GLYPHS[nibble];
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with inter-digit blanking,
// leading-zero suppression and frame-synchronous data commit.
module hex_display_scanner
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dot_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_n,
  output logic                    dot_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start,
  output logic                    pending,
  output state_e                  dbg_state
);

  localparam int MAX_CYC = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_LSB     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Handshake: load is a one-cycle strobe with no ready; it is always accepted
  // into the shadow registers. pending stays high until the shadow is copied
  // into the displayed registers at a frame boundary.

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic [DW-1:0]           active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]   active_dot_q, active_dot_d;
  logic [DW-1:0]           shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dot_q, shadow_dot_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dot_n_q, dot_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_start_q, frame_start_d;

  logic                    phase_done;
  logic                    boundary;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_glyph;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_above;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      active_data_q <= '0;
      active_dot_q  <= '0;
      shadow_data_q <= '0;
      shadow_dot_q  <= '0;
      pending_q     <= 1'b0;
      seg_n_q       <= SEG_OFF;
      dot_n_q       <= 1'b1;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      active_data_q <= active_data_d;
      active_dot_q  <= active_dot_d;
      shadow_data_q <= shadow_data_d;
      shadow_dot_q  <= shadow_dot_d;
      pending_q     <= pending_d;
      seg_n_q       <= seg_n_d;
      dot_n_q       <= dot_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    phase_done = (state_q == BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == SCAN_LAST);
    if (phase_done) begin
      cnt_d = '0;
      if (state_q == BLANK) begin
        state_d = SHOW;
      end else begin
        state_d = BLANK;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Frame boundary doubles as the commit point; the start-up pulse counts too.
  always_comb begin
    boundary      = (state_q == SHOW) && phase_done && (idx_q == IDX_LAST);
    frame_start_d = first_q | boundary;
    first_d       = 1'b0;
    active_data_d = active_data_q;
    active_dot_d  = active_dot_q;
    shadow_data_d = shadow_data_q;
    shadow_dot_d  = shadow_dot_q;
    pending_d     = pending_q;
    if (frame_start_d && pending_q) begin
      active_data_d = shadow_data_q;
      active_dot_d  = shadow_dot_q;
      pending_d     = 1'b0;
    end
    if (load) begin
      shadow_data_d = data_in;
      shadow_dot_d  = dot_in;
      pending_d     = 1'b1;
    end
  end

  // lz_mask[k] is set when nibbles k..top are all zero; digit 0 is never masked.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (active_data_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  always_comb begin
    cur_nibble = active_data_q[{idx_q, 2'b00} +: 4];
  end

  hex_glyph_decode u_decode (
    .nibble (cur_nibble),
    .seg_n  (cur_glyph)
  );

  always_comb begin
    an_n_d  = '1;
    seg_n_d = SEG_OFF;
    dot_n_d = 1'b1;
    if (state_q == SHOW) begin
      an_n_d  = ~(AN_LSB << idx_q);
      seg_n_d = (lz_blank && lz_mask[idx_q]) ? SEG_OFF : cur_glyph;
      dot_n_d = ~active_dot_q[idx_q];
    end
  end

  assign seg_n       = seg_n_q;
  assign dot_n       = dot_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: a timeline model derived from frame arithmetic
// checks every cycle, table rows check the glyphs shown per digit.
module tb_hex_display_scanner;
  import hex_disp_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int BC = 1;
  localparam int P  = SC + BC;
  localparam int FP = ND * P;

  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dot_in;
  logic        lz_blank;
  logic [6:0]  seg_n;
  logic        dot_n;
  logic [3:0]  an_n;
  logic        frame_start;
  logic        pending;
  state_e      dbg_state;

  hex_display_scanner #(
    .NUM_DIGITS   (ND),
    .SCAN_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .data_in     (data_in),
    .dot_in      (dot_in),
    .lz_blank    (lz_blank),
    .seg_n       (seg_n),
    .dot_n       (dot_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .pending     (pending),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int k;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_adot, m_sdot;
  logic        m_pending;
  logic [6:0]  cap_seg [4];
  logic        cap_dot [4];
  logic        cap_seen [4];

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dot;
    logic        lz;
    logic [27:0] seg;
    logic [3:0]  dotn;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_active = '0; m_shadow = '0; m_adot = '0; m_sdot = '0; m_pending = 1'b0;
  endtask

  // Outputs shown after j edges follow from position in the frame timeline.
  function automatic void model_out(input int j, output logic [3:0] an,
                                    output logic [6:0] seg, output logic dot);
    int v, d, r;
    logic [15:0] upper;
    v = j % FP; d = v / P; r = v % P;
    an = 4'hF; seg = 7'h7F; dot = 1'b1;
    if (r >= BC) begin
      an    = ~(4'b0001 << d);
      upper = m_active >> (4 * d);
      seg   = (lz_blank && d != 0 && upper == 16'h0) ? 7'h7F : GLY[upper[3:0]];
      dot   = ~m_adot[d];
    end
  endfunction

  task automatic step();
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        ed, efs, ld;
    logic [15:0] dd;
    logic [3:0]  dt;
    model_out(k, ea, es, ed);
    efs = (k + 1 == 1) || ((k + 1) % FP == 0);
    ld = load; dd = data_in; dt = dot_in;
    @(posedge clk);
    k++;
    if (efs && m_pending) begin
      m_active = m_shadow; m_adot = m_sdot; m_pending = 1'b0;
    end
    if (ld) begin
      m_shadow = dd; m_sdot = dt; m_pending = 1'b1;
    end
    @(negedge clk);
    chk("an_n", an_n, ea);
    chk("seg_n", seg_n, es);
    chk("dot_n", dot_n, ed);
    chk("frame_start", frame_start, efs);
    chk("pending", pending, m_pending);
    chk("no_x", $isunknown({seg_n, dot_n, an_n, frame_start, pending}), 0);
    for (int d = 0; d < ND; d++) begin
      if (ea == ~(4'b0001 << d)) begin
        cap_seg[d] = seg_n; cap_dot[d] = dot_n; cap_seen[d] = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dt);
    data_in = d; dot_in = dt; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic align();
    do step(); while (k % FP != 0);
  endtask

  task automatic capture_frame();
    for (int d = 0; d < ND; d++) cap_seen[d] = 1'b0;
    repeat (FP) step();
  endtask

  task automatic check_row(input string nm, input logic [27:0] seg, input logic [3:0] dotn);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_seen%0d", nm, d), cap_seen[d], 1);
      chk($sformatf("%s_seg%0d", nm, d), cap_seg[d], seg[7*d +: 7]);
      chk($sformatf("%s_dot%0d", nm, d), cap_dot[d], dotn[d]);
    end
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
    vecs[1] = '{16'h0030, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[4] = '{16'h0800, 4'b1001, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40}, 4'b0110};
    vecs[5] = '{16'h7E6D, 4'b0010, 1'b1, {7'h78, 7'h06, 7'h02, 7'h21}, 4'b1101};
    vecs[6] = '{16'hC3B4, 4'b0000, 1'b0, {7'h46, 7'h30, 7'h03, 7'h19}, 4'b1111};

    reset_n = 1'b0; load = 1'b0; data_in = '0; dot_in = '0; lz_blank = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dot_n", dot_n, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_pending", pending, 0);
    reset_n = 1'b1;
    model_reset();

    repeat (2 * FP + 5) step();

    // Table rows: load mid-frame, commit at the boundary, capture the next frame.
    for (int i = 0; i < 7; i++) begin
      lz_blank = vecs[i].lz;
      align();
      repeat (7) step();
      do_load(vecs[i].data, vecs[i].dot);
      repeat (5) step();
      chk($sformatf("row%0d_pend_hold", i), pending, 1);
      align();
      chk($sformatf("row%0d_pend_clr", i), pending, 0);
      capture_frame();
      check_row($sformatf("row%0d", i), vecs[i].seg, vecs[i].dotn);
    end

    // Loads landing exactly on commit edges in consecutive frames.
    lz_blank = 1'b0;
    align();
    repeat (FP - 1) step();
    do_load(16'h1111, 4'h0);
    chk("b1_pending", pending, 1);
    repeat (FP - 1) step();
    do_load(16'h2222, 4'h0);
    chk("b2_pending", pending, 1);
    capture_frame();
    check_row("ones", {4{7'h79}}, 4'hF);
    chk("b3_pending", pending, 0);
    capture_frame();
    check_row("twos", {4{7'h24}}, 4'hF);

    // Two loads in one frame: the later one is displayed.
    align();
    repeat (4) step();
    do_load(16'h3333, 4'hF);
    repeat (3) step();
    do_load(16'h5555, 4'h0);
    align();
    capture_frame();
    check_row("last_wins", {4{7'h12}}, 4'hF);

    // Randomized traffic against the timeline model.
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 14) == 0) begin
        do_load(16'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end

    // All sixteen glyphs on digit 0 with random upper digits.
    for (int n = 0; n < 16; n++) begin
      logic [15:0] d;
      d = {12'($urandom), 4'(n)};
      lz_blank = 1'($urandom);
      align();
      repeat (2) step();
      do_load(d, 4'($urandom));
      align();
      capture_frame();
      chk($sformatf("sweep_seen_%0h", n), cap_seen[0], 1);
      chk($sformatf("sweep_seg_%0h", n), cap_seg[0], GLY[n]);
    end

    // Asynchronous reset while digit 2 is lit, with a load still pending.
    lz_blank = 1'b0;
    align();
    repeat (3) step();
    do_load(16'hABCD, 4'hF);
    repeat (8) step();
    chk("pre_rst_an_n", an_n, 4'hB);
    chk("pre_rst_pending", pending, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an_n", an_n, 4'hF);
    chk("arst_seg_n", seg_n, 7'h7F);
    chk("arst_dot_n", dot_n, 1);
    chk("arst_frame_start", frame_start, 0);
    chk("arst_pending", pending, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    align();
    chk("post_rst_pending", pending, 0);
    capture_frame();
    check_row("post_rst", {4{7'h40}}, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
